mem_read_responder: RTL and testbench

- Memory-side responder for the cache fill protocol.
- Accepts one word request per cycle: a read or a write on a 16-bit byte address.
- Returns read data on a fixed-latency pipeline with a one-cycle data-valid strobe.
- Sits behind the memory arbiter and serves both the I-cache and D-cache fill engines, which issue consecutive word addresses and count returned valid strobes.

---
 rtl/mem_read_responder.sv | 99 +++++++++
 tb/tb_mem_read_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// mem_read_responder
//   Memory-side responder for the cache fill protocol. It accepts one word
//   request per cycle with no backpressure. A read returns its data after a
//   fixed LATENCY cycles, marked by a one-cycle data_valid strobe. A write
//   updates the array and produces no response.
//
// Ports
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   enable, wr   : request strobe; wr=1 selects write, wr=0 selects read
//   addr         : byte address; bits [MEM_AW:1] index the word array
//   data_in      : write data
//   data_out     : read data, forced to 0 while data_valid is low
//   data_valid   : one-cycle strobe per accepted read
//   data_addr    : byte address of the returned read (bit 0 cleared)
//   outstanding  : reads accepted but not yet returned (0..LATENCY)
module mem_read_responder #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_AW  = 10,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        outstanding
);
   localparam int STAGES = LATENCY - 1;
   localparam int DEPTH  = 1 << MEM_AW;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } stage_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [STAGES:0]   vld_pipe;
   stage_t            pay_pipe [STAGES:0];

   logic [MEM_AW-1:0] idx;
   logic              rd_acc;
   logic              wr_acc;
   logic              unused_addr_lsb;

   assign idx             = addr[MEM_AW:1];
   assign rd_acc          = enable & ~wr;
   assign wr_acc          = enable & wr;
   assign unused_addr_lsb = addr[0];

   // The array is not reset and keeps its contents through reset. Requests
   // seen while rst_n is low are still ignored, so rst_n gates the write.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc)
         mem[idx] <= data_in;
   end

   // Stage 0 samples the array at the accept edge. Both this block and the
   // write block use non-blocking updates, so the snapshot always sees the
   // pre-write contents. Idle cycles and writes shift in a cleared valid bit;
   // the payload of those bubbles is don't-care.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int i = 0; i <= STAGES; i++)
            pay_pipe[i] <= '0;
      end else begin
         vld_pipe[0]      <= rd_acc;
         pay_pipe[0].addr <= {addr[ADDR_W-1:1], 1'b0};
         pay_pipe[0].data <= mem[idx];
         for (int i = 1; i <= STAGES; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            pay_pipe[i] <= pay_pipe[i-1];
         end
      end
   end

   assign data_valid = vld_pipe[STAGES];
   assign data_out   = data_valid ? pay_pipe[STAGES].data : '0;
   assign data_addr  = pay_pipe[STAGES].addr;

   // This counter tracks the number of set bits in vld_pipe, so it is
   // bounded by LATENCY. An accept and a return in the same cycle cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         outstanding <= '0;
      else begin
         case ({rd_acc, data_valid})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   outstanding <= outstanding - 4'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_read_responder.sv
// tb_mem_read_responder
//   Drives one request stream into three responders built with LATENCY 1, 4
//   and 8. The reference model keeps a word array and a per-edge history of
//   accepted reads. For a block of latency L, the expected strobe in cycle c
//   is the read accepted at edge c-L+1. The expected outstanding count is the
//   number of reads accepted at edges c-L+1..c.
module tb_mem_read_responder;
   localparam int NI = 3;
   localparam int LATS [NI] = '{1, 4, 8};

   typedef struct {
      bit          v;
      logic [15:0] d;
      logic [15:0] a;
   } hist_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;

   logic [15:0] dout  [NI];
   logic        dv    [NI];
   logic [15:0] daddr [NI];
   logic [3:0]  outs  [NI];

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    peak [NI];
   logic [15:0] mm [1024];
   hist_t hist [0:4095];

   always #5 clk = ~clk;

   mem_read_responder #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
      .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0]),
      .data_addr(daddr[0]), .outstanding(outs[0]));
   mem_read_responder #(.LATENCY(4)) u_l4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
      .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1]),
      .data_addr(daddr[1]), .outstanding(outs[1]));
   mem_read_responder #(.LATENCY(8)) u_l8 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
      .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2]),
      .data_addr(daddr[2]), .outstanding(outs[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         int    base;
         int    cnt;
         bit    ev;
         string t;
         base = cyc - LATS[i] + 1;
         ev   = (base >= 1) ? hist[base].v : 1'b0;
         cnt  = 0;
         for (int k = (base < 1 ? 1 : base); k <= cyc; k++)
            if (hist[k].v) cnt++;
         t = $sformatf("L%0d", LATS[i]);
         chk({t, "_valid"}, 32'(dv[i]), 32'(ev));
         chk({t, "_data"}, 32'(dout[i]), ev ? 32'(hist[base].d) : 32'd0);
         chk({t, "_outstanding"}, 32'(outs[i]), 32'(cnt));
         if (ev)
            chk({t, "_addr"}, 32'(daddr[i]), 32'(hist[base].a));
         if (int'(outs[i]) > peak[i])
            peak[i] = int'(outs[i]);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s_L%0d_valid", tag, LATS[i]), 32'(dv[i]), 32'd0);
         chk($sformatf("%s_L%0d_data", tag, LATS[i]), 32'(dout[i]), 32'd0);
         chk($sformatf("%s_L%0d_addr", tag, LATS[i]), 32'(daddr[i]), 32'd0);
         chk($sformatf("%s_L%0d_outstanding", tag, LATS[i]), 32'(outs[i]), 32'd0);
      end
   endtask

   // Drive one request, let one rising edge accept it, then check at the
   // falling edge.
   task automatic step(input bit en, input bit w, input logic [15:0] a,
                       input logic [15:0] d);
      enable  = en;
      wr      = w;
      addr    = a;
      data_in = d;
      @(posedge clk);
      cyc++;
      hist[cyc].v = rst_n && en && !w;
      hist[cyc].d = mm[a[10:1]];
      hist[cyc].a = {a[15:1], 1'b0};
      if (rst_n && en && w)
         mm[a[10:1]] = d;
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      for (int i = 0; i < NI; i++) peak[i] = 0;
      for (int k = 0; k < 4096; k++) hist[k].v = 1'b0;
      rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
      #23;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 0x10..0x1E, then run a back-to-back burst of 8 reads.
      for (int k = 0; k < 8; k++)
         step(1'b1, 1'b1, 16'(16'h0010 + 2*k), 16'(16'h1111 * (k + 1)));
      for (int k = 0; k < 8; k++)
         step(1'b1, 1'b0, 16'(16'h0010 + 2*k), 16'h0);
      idle(10);
      for (int i = 0; i < NI; i++)
         chk($sformatf("peak_L%0d", LATS[i]), 32'(peak[i]), 32'(LATS[i]));

      // Odd byte address and upper-bit alias.
      step(1'b1, 1'b1, 16'h0020, 16'hBEEF);
      step(1'b1, 1'b0, 16'h0021, 16'h0);
      step(1'b1, 1'b0, 16'h0820, 16'h0);
      idle(9);

      // A write following a read must not alter the in-flight read.
      step(1'b1, 1'b1, 16'h0040, 16'hAAAA);
      step(1'b1, 1'b0, 16'h0040, 16'h0);
      step(1'b1, 1'b1, 16'h0040, 16'h5555);
      step(1'b1, 1'b0, 16'h0040, 16'h0);
      idle(9);

      // Read, idle, read, write, read: bubble pattern.
      step(1'b1, 1'b0, 16'h0012, 16'h0);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0014, 16'h0);
      step(1'b1, 1'b1, 16'h0060, 16'h1234);
      step(1'b1, 1'b0, 16'h0060, 16'h0);
      idle(9);

      // Reset two cycles into a 4-read burst.
      step(1'b1, 1'b0, 16'h0010, 16'h0);
      step(1'b1, 1'b0, 16'h0012, 16'h0);
      rst_n = 1'b0;
      for (int k = 0; k <= cyc; k++) hist[k].v = 1'b0;
      #1;
      check_reset_state("midreset");
      step(1'b1, 1'b0, 16'h0014, 16'h0);
      step(1'b1, 1'b1, 16'h0010, 16'hDEAD);   // ignored while reset is low
      rst_n = 1'b1;
      idle(10);
      step(1'b1, 1'b0, 16'h0010, 16'h0);
      step(1'b1, 1'b0, 16'h0020, 16'h0);
      step(1'b1, 1'b0, 16'h0040, 16'h0);
      idle(9);

      // Randomized traffic over 16 words, with aliased upper bits and a
      // random address bit 0.
      for (int k = 0; k < 16; k++)
         step(1'b1, 1'b1, 16'(16'h07E0 + 2*k), 16'($urandom));
      for (int k = 0; k < 300; k++) begin
         r = $urandom;
         step(r[20] | r[21], r[22] & r[23],
              {r[15:11], 6'b111111, r[3:0], r[4]}, r[31:16]);
      end
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
